axi_rd_arbiter: RTL and testbench
=================================

AXI_RD_ARBITER -- requirements
Module: axi_rd_arbiter

Interface
REQ-001 The block SHALL have one clock and one reset; reset is synchronous and active-low.
REQ-002 Parameter ID0, default 4'h1: ARID used for requester 0.
REQ-003 Parameter ID1, default 4'h2: ARID used for requester 1 (ID1 != ID0).
REQ-004 Ports, in this order:
- clk  in  1  clock; all logic on rising edge
- rst  in  1  synchronous reset, active-low
- reqN_valid (N=0,1)  in  1  requester N has a burst request
- reqN_addr  in  32  byte address, 8-byte aligned
- reqN_len  in  4  beats minus one
- reqN_ready  out  1  request accepted this cycle
- rdN_data  out  64  read data to requester N
- rdN_resp  out  2  RRESP copy
- rdN_last  out  1  last beat
- rdN_valid  out  1  beat valid
- rdN_ready  in  1  requester N accepts beat
- ARID/ARADDR/ARLEN/ARSIZE/ARBURST/ARLOCK/ARCACHE/ARPROT/ARQOS/ARREGION/ARUSER  out  4/32/4/3/2/2/4/3/1/1/1  AXI read address
- ARVALID  out  1
- ARREADY  in  1
- RID/RDATA/RRESP/RLAST/RUSER/RVALID  in  4/64/2/1/1/1  AXI read data
- RREADY  out  1
- prot_err  out  1  sticky protocol-error flag

Function
REQ-005 States: IDLE, ADDR, DATA; one burst outstanding at a time.
REQ-006 IDLE: if any reqN_valid, select grant; reqN_ready=1 for the granted N in that same cycle (combinational); latch addr/len/grant; next ADDR.
REQ-007 Arbitration: round-robin; if both are valid, grant the requester not served last; last-served resets to 1, so requester 0 wins the first contention.
REQ-008 ADDR: ARVALID=1, AR fields held stable from the latch; ARID = ID of grant; ARSIZE=3'b011, ARBURST=2'b01, all other AR sideband outputs 0; on ARVALID&&ARREADY -> DATA (same-cycle ARREADY accepted).
REQ-009 DATA: RREADY = rdG_ready of granted G; rdG_valid = RVALID; rdG_data/resp/last = RDATA/RRESP/RLAST; pass-through, zero latency; non-granted rd*_valid = 0.
REQ-010 Beat counter: 5 bits, cleared on entry to DATA, increments on each RVALID&&RREADY; expected beats = len+1 (1..16).
REQ-011 On RVALID&&RREADY&&RLAST -> IDLE and update last-served; the next grant is possible on the following cycle.
REQ-012 prot_err set (sticky until reset) if a handshaken beat has RID != granted ID, RLAST on a beat other than beat len+1, or no RLAST on beat len+1; a missing RLAST does not end the burst; RUSER is ignored.
REQ-013 Outside DATA: RREADY=0; all rd*_valid=0.
REQ-014 A request that drops reqN_valid before grant is simply not served; requests are not queued.

Reset
REQ-015 When rst=0 at a clock edge: state=IDLE, ARVALID=0, RREADY=0, AR fields=0, counter=0, last-served=1, prot_err=0; reqN_ready and rdN_valid are 0 during reset.
REQ-016 Reset in ADDR or DATA abandons the burst; no further R beats are forwarded.

Structure
REQ-017 Shared package axi_pkg holds the state enum, burst/size constants (INCR=2'b01, SIZE_8B=3'b011) and RESP codes.
REQ-018 One sub-module rr_arb2 SHALL implement two-input round-robin arbitration (req[1:0], last, grant).

Verification
REQ-019 Single request: req0 addr 32'h1000 len 3, ARREADY after 2 cycles -> ARID=4'h1, ARLEN=3, four beats on rd0, rd1_valid=0, prot_err=0.
REQ-020 Contention: both valid in IDLE from reset -> req0 granted first, then req1 (ARID=4'h2), then req0 again.
REQ-021 Backpressure: rd1_ready low for 3 cycles mid-burst -> RREADY low for those cycles, no beat lost or duplicated.
REQ-022 Errors: RLAST on beat 2 of len 3 -> prot_err=1 and return to IDLE; RID=4'h5 -> prot_err=1.
REQ-023 Reset mid-DATA after 2 beats -> next cycle IDLE, RREADY=0, prot_err=0, and a new request proceeds normally.

Source files
------------

// File: rtl/axi_pkg.sv
// Shared AXI read-side definitions: controller states, burst/size encodings
// and response codes.
package axi_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } rd_state_e;

  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [2:0] SIZE_8B     = 3'b011;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

endpackage

// File: rtl/rr_arb2.sv
// Two-input round-robin selector: on contention the requester not served
// last wins; a lone requester always wins.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic       grant,
  output logic       any
);

  always_comb begin
    any = |req;
    if (req == 2'b11) grant = ~last;
    else              grant = req[1];
  end

endmodule

// File: rtl/axi_rd_arbiter.sv
// Two-requester AXI read arbiter: one burst outstanding, AR issued from
// latched request, R beats passed through to the granted requester.
module axi_rd_arbiter
  import axi_pkg::*;
#(
  parameter logic [3:0] ID0 = 4'h1,
  parameter logic [3:0] ID1 = 4'h2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0_valid,
  input  logic [31:0] req0_addr,
  input  logic [3:0]  req0_len,
  output logic        req0_ready,
  input  logic        req1_valid,
  input  logic [31:0] req1_addr,
  input  logic [3:0]  req1_len,
  output logic        req1_ready,
  output logic [63:0] rd0_data,
  output logic [1:0]  rd0_resp,
  output logic        rd0_last,
  output logic        rd0_valid,
  input  logic        rd0_ready,
  output logic [63:0] rd1_data,
  output logic [1:0]  rd1_resp,
  output logic        rd1_last,
  output logic        rd1_valid,
  input  logic        rd1_ready,
  output logic [3:0]  ARID,
  output logic [31:0] ARADDR,
  output logic [3:0]  ARLEN,
  output logic [2:0]  ARSIZE,
  output logic [1:0]  ARBURST,
  output logic [1:0]  ARLOCK,
  output logic [3:0]  ARCACHE,
  output logic [2:0]  ARPROT,
  output logic        ARQOS,
  output logic        ARREGION,
  output logic        ARUSER,
  output logic        ARVALID,
  input  logic        ARREADY,
  input  logic [3:0]  RID,
  input  logic [63:0] RDATA,
  input  logic [1:0]  RRESP,
  input  logic        RLAST,
  input  logic        RUSER,
  input  logic        RVALID,
  output logic        RREADY,
  output logic        prot_err
);

  rd_state_e   state_q;
  logic        grant_q, last_q, prot_err_q;
  logic [31:0] addr_q;
  logic [3:0]  len_q, arid_q;
  logic [2:0]  arsize_q;
  logic [1:0]  arburst_q;
  logic [4:0]  beat_q;

  logic arb_grant, arb_any, take, in_data, r_hs, final_beat, beat_err;
  logic unused_ruser;

  rr_arb2 u_arb (
    .req   ({req1_valid, req0_valid}),
    .last  (last_q),
    .grant (arb_grant),
    .any   (arb_any)
  );

  // Grant is visible in the same IDLE cycle; everything is masked while in reset.
  assign take       = rst && (state_q == IDLE) && arb_any;
  assign req0_ready = take && !arb_grant;
  assign req1_ready = take &&  arb_grant;

  assign in_data    = rst && (state_q == DATA);
  assign RREADY     = in_data && (grant_q ? rd1_ready : rd0_ready);
  assign rd0_valid  = in_data && !grant_q && RVALID;
  assign rd1_valid  = in_data &&  grant_q && RVALID;
  assign rd0_data   = RDATA;
  assign rd0_resp   = RRESP;
  assign rd0_last   = RLAST;
  assign rd1_data   = RDATA;
  assign rd1_resp   = RRESP;
  assign rd1_last   = RLAST;

  assign r_hs       = in_data && RVALID && RREADY;
  assign final_beat = (beat_q == {1'b0, len_q});
  assign beat_err   = (RID != arid_q) || (RLAST != final_beat);
  assign unused_ruser = RUSER;

  assign ARVALID  = (state_q == ADDR);
  assign ARID     = arid_q;
  assign ARADDR   = addr_q;
  assign ARLEN    = len_q;
  assign ARSIZE   = arsize_q;
  assign ARBURST  = arburst_q;
  assign ARLOCK   = 2'b00;
  assign ARCACHE  = 4'h0;
  assign ARPROT   = 3'b000;
  assign ARQOS    = 1'b0;
  assign ARREGION = 1'b0;
  assign ARUSER   = 1'b0;
  assign prot_err = prot_err_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= IDLE;
      grant_q    <= 1'b0;
      last_q     <= 1'b1;
      prot_err_q <= 1'b0;
      addr_q     <= '0;
      len_q      <= '0;
      arid_q     <= '0;
      arsize_q   <= '0;
      arburst_q  <= '0;
      beat_q     <= '0;
    end else begin
      case (state_q)
        IDLE: if (take) begin
          grant_q   <= arb_grant;
          addr_q    <= arb_grant ? req1_addr : req0_addr;
          len_q     <= arb_grant ? req1_len  : req0_len;
          arid_q    <= arb_grant ? ID1 : ID0;
          arsize_q  <= SIZE_8B;
          arburst_q <= BURST_INCR;
          state_q   <= ADDR;
        end
        ADDR: if (ARREADY) begin
          beat_q  <= '0;
          state_q <= DATA;
        end
        DATA: if (r_hs) begin
          beat_q <= beat_q + 5'd1;
          if (beat_err) prot_err_q <= 1'b1;
          // Only RLAST closes the burst, even when it arrives on the wrong beat.
          if (RLAST) begin
            last_q  <= grant_q;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Bench for axi_rd_arbiter: scenario tasks drive an AXI slave model; a monitor
// pops expected beats from per-requester scoreboards.
module tb_axi_rd_arbiter;

  logic        clk = 0, rst = 0;
  logic        req0_valid = 0, req1_valid = 0;
  logic [31:0] req0_addr = 0, req1_addr = 0;
  logic [3:0]  req0_len = 0, req1_len = 0;
  logic        req0_ready, req1_ready;
  logic [63:0] rd0_data, rd1_data;
  logic [1:0]  rd0_resp, rd1_resp;
  logic        rd0_last, rd1_last, rd0_valid, rd1_valid;
  logic        rd0_ready = 1, rd1_ready = 1;
  logic [3:0]  ARID, ARLEN, ARCACHE;
  logic [31:0] ARADDR;
  logic [2:0]  ARSIZE, ARPROT;
  logic [1:0]  ARBURST, ARLOCK;
  logic        ARQOS, ARREGION, ARUSER, ARVALID;
  logic        ARREADY = 0;
  logic [3:0]  RID = 0;
  logic [63:0] RDATA = 0;
  logic [1:0]  RRESP = 0;
  logic        RLAST = 0, RUSER = 0, RVALID = 0;
  logic        RREADY, prot_err;

  int checks = 0;
  int errors = 0;
  logic [66:0] sb0[$];
  logic [66:0] sb1[$];

  always #5 clk = ~clk;

  axi_rd_arbiter dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_len(req0_len), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_len(req1_len), .req1_ready(req1_ready),
    .rd0_data(rd0_data), .rd0_resp(rd0_resp), .rd0_last(rd0_last), .rd0_valid(rd0_valid), .rd0_ready(rd0_ready),
    .rd1_data(rd1_data), .rd1_resp(rd1_resp), .rd1_last(rd1_last), .rd1_valid(rd1_valid), .rd1_ready(rd1_ready),
    .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARBURST(ARBURST),
    .ARLOCK(ARLOCK), .ARCACHE(ARCACHE), .ARPROT(ARPROT), .ARQOS(ARQOS), .ARREGION(ARREGION),
    .ARUSER(ARUSER), .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RUSER(RUSER), .RVALID(RVALID),
    .RREADY(RREADY), .prot_err(prot_err)
  );

  // Beat monitor: every forwarded handshake must match the oldest expected beat.
  always begin
    @(negedge clk);
    #2;
    if (rd0_valid && rd1_valid) begin
      errors++; $display("FAIL both_rd_valid: rd0_valid=%0b rd1_valid=%0b, required one-hot", rd0_valid, rd1_valid);
    end
    if (rd0_valid && rd0_ready) begin
      checks++;
      if (sb0.size() == 0) begin
        errors++; $display("FAIL rd0_unexpected_beat: data=%h, required no beat", rd0_data);
      end else begin
        logic [66:0] e0;
        e0 = sb0.pop_front();
        if ({rd0_resp, rd0_last, rd0_data} !== e0) begin
          errors++; $display("FAIL rd0_beat: got %h required %h", {rd0_resp, rd0_last, rd0_data}, e0);
        end
      end
    end
    if (rd1_valid && rd1_ready) begin
      checks++;
      if (sb1.size() == 0) begin
        errors++; $display("FAIL rd1_unexpected_beat: data=%h, required no beat", rd1_data);
      end else begin
        logic [66:0] e1;
        e1 = sb1.pop_front();
        if ({rd1_resp, rd1_last, rd1_data} !== e1) begin
          errors++; $display("FAIL rd1_beat: got %h required %h", {rd1_resp, rd1_last, rd1_data}, e1);
        end
      end
    end
  end

  task automatic set_rdy(input int n, input logic v);
    if (n == 0) rd0_ready = v;
    else        rd1_ready = v;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 0; req0_valid = 0; req1_valid = 0; RVALID = 0; RLAST = 0; ARREADY = 0;
    rd0_ready = 1; rd1_ready = 1;
    repeat (2) @(negedge clk);
    rst = 1;
    sb0.delete(); sb1.delete();
  endtask

  // AXI slave model for one burst; reports what was seen on AR and whether
  // RREADY leaked during requester backpressure. stop_after>=0 leaves that
  // beat presented (unexpected) and returns early.
  task automatic serve_burst(input int n, input int len, input int ar_wait, input logic [3:0] rid,
                             input int last_at, input int bp_at, input int bp_cyc, input int stop_after,
                             output logic [3:0] o_id, output logic [31:0] o_addr, output logic [3:0] o_len,
                             output bit o_ok, output bit o_leak);
    logic [66:0] eb;
    int t;
    o_ok = 1; o_leak = 0; o_id = '0; o_addr = '0; o_len = '0;
    t = 0;
    while (!ARVALID && t < 20) begin @(negedge clk); #1; t++; end
    if (!ARVALID) begin o_ok = 0; return; end
    o_id = ARID; o_addr = ARADDR; o_len = ARLEN;
    for (int k = 0; k < ar_wait; k++) begin
      @(negedge clk); #1;
      if (!ARVALID || ARADDR !== o_addr) o_ok = 0;
    end
    @(negedge clk); ARREADY = 1;
    @(negedge clk); ARREADY = 0;
    for (int b = 0; b <= len; b++) begin
      RVALID = 1; RID = rid; RRESP = 2'(b); RLAST = (b == last_at);
      RDATA  = {16'hBEEF, 8'(n), 8'(b), o_addr + 32'(b * 8)};
      if (b == stop_after) return;
      eb = {RRESP, RLAST, RDATA};
      if (n == 0) sb0.push_back(eb);
      else        sb1.push_back(eb);
      if (b == bp_at) begin
        set_rdy(n, 0);
        for (int k = 0; k < bp_cyc; k++) begin
          #1; if (RREADY) o_leak = 1;
          @(negedge clk);
        end
        set_rdy(n, 1);
      end
      t = 0; #1;
      while (!RREADY && t < 20) begin @(negedge clk); #1; t++; end
      if (!RREADY) begin o_ok = 0; RVALID = 0; return; end
      @(negedge clk);
      if (RLAST) break;
    end
    RVALID = 0; RLAST = 0;
  endtask

  logic [3:0]  g_id, g_len;
  logic [31:0] g_addr;
  bit          g_ok, g_leak;

  task automatic test_reset();
    rst = 0; req0_valid = 1; req0_addr = 32'h40; RVALID = 1;
    repeat (2) @(negedge clk);
    #1;
    checks++; if (req0_ready !== 1'b0) begin errors++; $display("FAIL reset_req0_ready: got %b required 0", req0_ready); end
    checks++; if (ARVALID !== 1'b0)    begin errors++; $display("FAIL reset_arvalid: got %b required 0", ARVALID); end
    checks++; if (RREADY !== 1'b0)     begin errors++; $display("FAIL reset_rready: got %b required 0", RREADY); end
    checks++; if (prot_err !== 1'b0)   begin errors++; $display("FAIL reset_prot_err: got %b required 0", prot_err); end
    checks++; if ({ARID, ARADDR, ARLEN} !== 40'h0) begin errors++; $display("FAIL reset_ar_fields: got %h required 0", {ARID, ARADDR, ARLEN}); end
    checks++; if (rd0_valid !== 1'b0)  begin errors++; $display("FAIL reset_rd0_valid: got %b required 0", rd0_valid); end
    @(negedge clk);
    req0_valid = 0; RVALID = 0; rst = 1;
  endtask

  task automatic test_single();
    do_reset();
    req0_valid = 1; req0_addr = 32'h1000; req0_len = 4'd3;
    #1;
    checks++; if ({req1_ready, req0_ready} !== 2'b01) begin errors++; $display("FAIL single_grant: got %b required 01", {req1_ready, req0_ready}); end
    @(negedge clk); req0_valid = 0; #1;
    checks++; if ({ARVALID, ARSIZE, ARBURST} !== 6'b1_011_01) begin errors++; $display("FAIL single_ar_ctrl: got %b required 101101", {ARVALID, ARSIZE, ARBURST}); end
    checks++; if ({ARLOCK, ARCACHE, ARPROT, ARQOS, ARREGION, ARUSER} !== 12'h0) begin errors++; $display("FAIL single_ar_side: got %h required 0", {ARLOCK, ARCACHE, ARPROT, ARQOS, ARREGION, ARUSER}); end
    serve_burst(0, 3, 2, 4'h1, 3, -1, 0, -1, g_id, g_addr, g_len, g_ok, g_leak);
    checks++; if (g_ok !== 1'b1)    begin errors++; $display("FAIL single_ok: got %b required 1", g_ok); end
    checks++; if ({g_id, g_len, g_addr} !== {4'h1, 4'd3, 32'h1000}) begin errors++; $display("FAIL single_ar: got %h required 131000", {g_id, g_len, g_addr}); end
    checks++; if (prot_err !== 1'b0) begin errors++; $display("FAIL single_prot_err: got %b required 0", prot_err); end
    checks++; if (sb0.size() !== 0)  begin errors++; $display("FAIL single_beats_left: got %0d required 0", sb0.size()); end
  endtask

  task automatic test_contention();
    do_reset();
    req0_valid = 1; req0_addr = 32'h2000; req0_len = 4'd0;
    req1_valid = 1; req1_addr = 32'h3000; req1_len = 4'd1;
    #1;
    checks++; if ({req1_ready, req0_ready} !== 2'b01) begin errors++; $display("FAIL cont_first: got %b required 01", {req1_ready, req0_ready}); end
    serve_burst(0, 0, 0, 4'h1, 0, -1, 0, -1, g_id, g_addr, g_len, g_ok, g_leak);
    checks++; if ({g_ok, g_id, g_addr} !== {1'b1, 4'h1, 32'h2000}) begin errors++; $display("FAIL cont_ar0: got %h required 112000", {g_ok, g_id, g_addr}); end
    #1;
    checks++; if ({req1_ready, req0_ready} !== 2'b10) begin errors++; $display("FAIL cont_second: got %b required 10", {req1_ready, req0_ready}); end
    serve_burst(1, 1, 1, 4'h2, 1, -1, 0, -1, g_id, g_addr, g_len, g_ok, g_leak);
    checks++; if ({g_ok, g_id, g_len, g_addr} !== {1'b1, 4'h2, 4'd1, 32'h3000}) begin errors++; $display("FAIL cont_ar1: got %h required 1213000", {g_ok, g_id, g_len, g_addr}); end
    #1;
    checks++; if ({req1_ready, req0_ready} !== 2'b01) begin errors++; $display("FAIL cont_third: got %b required 01", {req1_ready, req0_ready}); end
    serve_burst(0, 0, 0, 4'h1, 0, -1, 0, -1, g_id, g_addr, g_len, g_ok, g_leak);
    req0_valid = 0; req1_valid = 0;
    checks++; if ({g_ok, g_id} !== {1'b1, 4'h1}) begin errors++; $display("FAIL cont_ar2: got %h required 11", {g_ok, g_id}); end
    checks++; if (sb0.size() + sb1.size() !== 0) begin errors++; $display("FAIL cont_beats_left: got %0d required 0", sb0.size() + sb1.size()); end
  endtask

  task automatic test_backpressure();
    req1_valid = 1; req1_addr = 32'h4000; req1_len = 4'd5;
    @(negedge clk); req1_valid = 0;
    serve_burst(1, 5, 0, 4'h2, 5, 2, 3, -1, g_id, g_addr, g_len, g_ok, g_leak);
    checks++; if (g_ok !== 1'b1)    begin errors++; $display("FAIL bp_ok: got %b required 1", g_ok); end
    checks++; if (g_leak !== 1'b0)  begin errors++; $display("FAIL bp_rready_leak: got %b required 0", g_leak); end
    checks++; if (sb1.size() !== 0) begin errors++; $display("FAIL bp_beats_left: got %0d required 0", sb1.size()); end
    checks++; if (prot_err !== 1'b0) begin errors++; $display("FAIL bp_prot_err: got %b required 0", prot_err); end
  endtask

  task automatic test_errors();
    do_reset();
    #1;
    checks++; if (prot_err !== 1'b0) begin errors++; $display("FAIL err_clear: got %b required 0", prot_err); end
    req0_valid = 1; req0_addr = 32'h5000; req0_len = 4'd3;
    @(negedge clk); req0_valid = 0;
    serve_burst(0, 3, 0, 4'h1, 1, -1, 0, -1, g_id, g_addr, g_len, g_ok, g_leak);
    checks++; if ({g_ok, prot_err} !== 2'b11) begin errors++; $display("FAIL err_early_last: got ok,err=%b required 11", {g_ok, prot_err}); end
    req1_valid = 1; req1_addr = 32'h5800; req1_len = 4'd0;
    #1;
    checks++; if (req1_ready !== 1'b1) begin errors++; $display("FAIL err_back_to_idle: got %b required 1", req1_ready); end
    @(negedge clk); req1_valid = 0;
    serve_burst(1, 0, 0, 4'h2, 0, -1, 0, -1, g_id, g_addr, g_len, g_ok, g_leak);
    checks++; if ({g_ok, prot_err} !== 2'b11) begin errors++; $display("FAIL err_sticky: got ok,err=%b required 11", {g_ok, prot_err}); end
    do_reset();
    req1_valid = 1; req1_addr = 32'h5900; req1_len = 4'd0;
    @(negedge clk); req1_valid = 0;
    #1;
    checks++; if (prot_err !== 1'b0) begin errors++; $display("FAIL err_cleared_by_reset: got %b required 0", prot_err); end
    serve_burst(1, 0, 0, 4'h5, 0, -1, 0, -1, g_id, g_addr, g_len, g_ok, g_leak);
    checks++; if ({g_ok, prot_err} !== 2'b11) begin errors++; $display("FAIL err_bad_rid: got ok,err=%b required 11", {g_ok, prot_err}); end
    checks++; if (sb0.size() + sb1.size() !== 0) begin errors++; $display("FAIL err_beats_left: got %0d required 0", sb0.size() + sb1.size()); end
  endtask

  task automatic test_reset_mid_burst();
    do_reset();
    req0_valid = 1; req0_addr = 32'h6000; req0_len = 4'd7;
    @(negedge clk); req0_valid = 0;
    serve_burst(0, 7, 0, 4'h1, 7, -1, 0, 2, g_id, g_addr, g_len, g_ok, g_leak);
    rst = 0;
    #1;
    checks++; if ({RREADY, rd0_valid} !== 2'b00) begin errors++; $display("FAIL mid_reset_fwd: got rready,valid=%b required 00", {RREADY, rd0_valid}); end
    @(negedge clk);
    rst = 1; RVALID = 0;
    #1;
    checks++; if ({ARVALID, RREADY, prot_err} !== 3'b000) begin errors++; $display("FAIL mid_after_reset: got %b required 000", {ARVALID, RREADY, prot_err}); end
    checks++; if (sb0.size() !== 0) begin errors++; $display("FAIL mid_two_beats: got %0d left required 0", sb0.size()); end
    req1_valid = 1; req1_addr = 32'h7000; req1_len = 4'd1;
    #1;
    checks++; if (req1_ready !== 1'b1) begin errors++; $display("FAIL mid_idle_grant: got %b required 1", req1_ready); end
    @(negedge clk); req1_valid = 0;
    serve_burst(1, 1, 1, 4'h2, 1, -1, 0, -1, g_id, g_addr, g_len, g_ok, g_leak);
    checks++; if ({g_ok, g_id, g_len, g_addr} !== {1'b1, 4'h2, 4'd1, 32'h7000}) begin errors++; $display("FAIL mid_new_burst: got %h required 1217000", {g_ok, g_id, g_len, g_addr}); end
    checks++; if ({prot_err, 32'(sb1.size())} !== 33'd0) begin errors++; $display("FAIL mid_new_clean: err=%b left=%0d required 0,0", prot_err, sb1.size()); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_backpressure();
    test_errors();
    test_reset_mid_burst();
    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
